datamem_lanes: RTL and testbench

//  Parametrised byte-addressable data memory for the single-cycle/multicycle datapath.
//  - Supports byte and full-word loads and stores with per-lane write enables.
//  - Sign- or zero-extends byte loads.
//  - Flags misaligned word accesses.
//  - Clears its contents with a hardware sweep after reset or on request.

---
 rtl/dp_pkg.sv | 31 +++
 rtl/datamem_lanes_ram.sv | 40 ++++
 rtl/datamem_lanes.sv | 148 ++++++++++++++
 tb/tb_datamem_lanes.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the data-memory datapath: access sizes, FSM states and
// the byte-lane extension helper.
package dp_pkg;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    // Widest word lane_extend can produce; callers truncate to their own width.
    localparam int unsigned MAX_W = 128;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    function automatic logic [MAX_W-1:0] lane_extend(input logic [7:0]  b,
                                                     input logic        sext,
                                                     input int unsigned width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < 8) begin
                r[i] = b[i[2:0]];
            end else if (i < width) begin
                r[i] = sext & b[7];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/datamem_lanes_ram.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a registered read port.
module datamem_lanes_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned LANES = DATA_W / 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LANES-1:0]  we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are not reset; the owner zeroes them with a sweep.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < int'(LANES); l++) begin
            if (we_i[l]) begin
                mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_lanes.sv
// Byte-addressable data memory: byte/word loads and stores, byte-load extension,
// misaligned-word rejection and a zeroing sweep after reset or on clr.
module datamem_lanes
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic              size_i,
    input  logic              sext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              misalign_o
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               rvalid_q;
    logic               misalign_q;
    logic [OFF_W-1:0]   ld_lane_q;
    logic               ld_word_q;
    logic               ld_sext_q;
    logic               ld_zero_q;

    logic [OFF_W-1:0]   lane;
    logic [IDX_W-1:0]   idx;
    logic               is_word;
    logic               mis;
    logic               accept;
    logic               st_ok;
    logic               ld;

    logic [LANES-1:0]   ram_we;
    logic [IDX_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    logic [7:0]         ld_byte;
    logic [DATA_W-1:0]  ld_ext;
    logic               unused_addr;

    assign lane    = addr_i[OFF_W-1:0];
    assign idx     = addr_i[OFF_W +: IDX_W];
    assign is_word = (size_i == SZ_WORD);
    assign mis     = is_word && (lane != '0);
    // clr wins over a same-cycle request, which is simply dropped.
    assign accept  = req_i && (state_q == ST_IDLE) && !clr_i;
    assign st_ok   = accept && we_i && !mis;
    assign ld      = accept && !we_i;

    // Upper address bits wrap the access modulo DEPTH.
    assign unused_addr = ^addr_i[ADDR_W-1:OFF_W+IDX_W];

    always_comb begin
        ram_we    = '0;
        ram_waddr = idx;
        ram_wdata = is_word ? wdata_i : {LANES{wdata_i[7:0]}};
        if (state_q == ST_CLEAR) begin
            ram_we    = '1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
        end else if (st_ok) begin
            ram_we = is_word ? '1 : ({{(LANES-1){1'b0}}, 1'b1} << lane);
        end
    end

    datamem_lanes_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ld && !mis),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            ld_lane_q  <= '0;
            ld_word_q  <= 1'b0;
            ld_sext_q  <= 1'b0;
            ld_zero_q  <= 1'b0;
        end else begin
            rvalid_q   <= ld;
            misalign_q <= accept && mis;
            // Load attributes only change on an accepted load, so rdata holds between pulses.
            if (ld) begin
                ld_lane_q <= lane;
                ld_word_q <= is_word;
                ld_sext_q <= sext_i;
                ld_zero_q <= mis;
            end
            unique case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        ld_byte = ram_rdata[{ld_lane_q, 3'b000} +: 8];
        ld_ext  = DATA_W'(lane_extend(ld_byte, ld_sext_q, DATA_W));
        if (ld_zero_q) begin
            rdata_o = '0;
        end else if (ld_word_q) begin
            rdata_o = ram_rdata;
        end else begin
            rdata_o = ld_ext;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign rvalid_o   = rvalid_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_datamem_lanes.sv
// Self-checking bench for datamem_lanes: vector table through a scoreboard queue,
// plus hand sequences for reset, clear sweep and reset mid-sweep.
module tb_datamem_lanes;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst, clr, req, we, size, sext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready, rvalid, misalign;
    logic [DATA_W-1:0] rdata;

    always #5 clk = ~clk;

    datamem_lanes #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .req_i      (req),
        .we_i       (we),
        .size_i     (size),
        .sext_i     (sext),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .ready_o    (ready),
        .rdata_o    (rdata),
        .rvalid_o   (rvalid),
        .misalign_o (misalign)
    );

    typedef struct {
        logic        req, we, size, sext;
        logic [15:0] addr, wdata;
        logic        rv, mis;
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        logic        rv, mis;
        logic [15:0] rd;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[19];
    int          passed = 0;
    int          total  = 0;
    logic [15:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic s, input logic x,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic rv, input logic mis, input logic [15:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.size = s; v.sext = x; v.addr = a; v.wdata = d;
        v.rv = rv; v.mis = mis; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic s, input logic x,
                         input logic [15:0] a, input logic [15:0] d);
        req = r; we = w; size = s; sext = x; addr = a; wdata = d;
    endtask

    // Drive one access, push its expected outcome, clock it, then pop and compare.
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        drive(v.req, v.we, v.size, v.sext, v.addr, v.wdata);
        e.rv = v.rv; e.mis = v.mis; e.rd = v.rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.rv) last_rd = e.rd;
            chk({name, "_rvalid"}, {31'd0, rvalid}, {31'd0, e.rv});
            chk({name, "_misalign"}, {31'd0, misalign}, {31'd0, e.mis});
            chk({name, "_rdata"}, {16'd0, rdata}, {16'd0, last_rd});
        end
    endtask

    // Count cycles until ready rises (bounded); optionally offer stores while low.
    task automatic wait_ready(input bit st, output int n);
        n = 0;
        while (!ready && n < 40) begin
            if (st) drive(1, 1, 1, 0, 16'h0004, 16'h7777);
            @(posedge clk);
            #1;
            n++;
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        last_rd = 16'h0;

        tbl[0]  = mk(1, 1, 1, 0, 16'h0004, 16'hBEEF, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 0, 1, 0, 16'h0004, 16'h0000, 1, 0, 16'hBEEF);
        tbl[2]  = mk(1, 1, 1, 0, 16'h0004, 16'h1234, 0, 0, 16'h0000);
        tbl[3]  = mk(1, 1, 0, 0, 16'h0005, 16'h0080, 0, 0, 16'h0000);
        tbl[4]  = mk(1, 0, 1, 0, 16'h0004, 16'h0000, 1, 0, 16'h8034);
        tbl[5]  = mk(1, 0, 0, 1, 16'h0005, 16'h0000, 1, 0, 16'hFF80);
        tbl[6]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        tbl[7]  = mk(1, 0, 0, 0, 16'h0005, 16'h0000, 1, 0, 16'h0080);
        tbl[8]  = mk(1, 0, 0, 1, 16'h0004, 16'h0000, 1, 0, 16'h0034);
        tbl[9]  = mk(1, 1, 1, 0, 16'h0002, 16'h1111, 0, 0, 16'h0000);
        tbl[10] = mk(1, 1, 1, 0, 16'h0003, 16'h5555, 0, 1, 16'h0000);
        tbl[11] = mk(1, 0, 1, 0, 16'h0002, 16'h0000, 1, 0, 16'h1111);
        tbl[12] = mk(1, 0, 1, 0, 16'h0003, 16'h0000, 1, 1, 16'h0000);
        tbl[13] = mk(1, 1, 1, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000);
        tbl[14] = mk(1, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'hAAAA);
        tbl[15] = mk(1, 0, 0, 0, 16'h0021, 16'h0000, 1, 0, 16'h00AA);
        tbl[16] = mk(1, 1, 0, 1, 16'h0008, 16'h7F01, 0, 0, 16'h0000);
        tbl[17] = mk(1, 0, 1, 0, 16'h0008, 16'h0000, 1, 0, 16'h0001);
        tbl[18] = mk(1, 0, 0, 1, 16'h0009, 16'h0000, 1, 0, 16'h0000);

        // Reset and initial sweep
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        wait_ready(0, n);
        chk("reset_sweep_len", n, 32'd16);
        apply("post_reset_load", mk(1, 0, 1, 0, 16'h000E, 16'h0, 1, 0, 16'h0000));

        for (int i = 0; i < 19; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // clr in IDLE drops a same-cycle load, then sweeps every word to zero
        clr = 1'b1;
        apply("clr_drops_req", mk(1, 0, 1, 0, 16'h0004, 16'h0, 0, 0, 16'h0000));
        clr = 1'b0;
        wait_ready(0, n);
        chk("clr_sweep_len", n, 32'd16);
        for (int i = 0; i < int'(DEPTH); i++) begin
            apply($sformatf("clr_word%0d", i),
                  mk(1, 0, 1, 0, 16'(2 * i), 16'h0, 1, 0, 16'h0000));
        end

        // Reset at sweep cycle 7 restarts the sweep; requests in CLEAR are ignored
        apply("pre_rst_store", mk(1, 1, 1, 0, 16'h000A, 16'h4321, 0, 0, 16'h0000));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 16'h0;
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("clear_load%0d", i),
                  mk(1, 0, 1, 0, 16'h000A, 16'h0, 0, 0, 16'h0000));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(1, n);
        chk("restart_sweep_len", n, 32'd16);
        apply("clear_store_ignored", mk(1, 0, 1, 0, 16'h0004, 16'h0, 1, 0, 16'h0000));
        apply("restart_zeroed", mk(1, 0, 1, 0, 16'h000A, 16'h0, 1, 0, 16'h0000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
